// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single-port data RAM between the CPU decoder and the ext loader (ext priority, CPU starvation bound).
// Latency: grant one cycle after a request is sampled in IDLE; read data RD_LAT+1 cycles after the grant.
// Backpressure: a requester holds its command until its gnt; requests are only sampled in IDLE.
module mem_port_arbiter #(
    parameter int RD_LAT  = 1,
    parameter int EXT_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [7:0]  ext_addr,
    input  logic [15:0] ext_wdata,
    output logic        ext_gnt,
    output logic [15:0] ext_rdata,
    output logic        ext_rvalid,
    output logic        ram_en,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [1:0]  wait_cnt, wait_nxt;
    logic        owner, owner_nxt;      // 1 = ext owns the outstanding transaction
    logic        launch, ext_win, rd_done;
    logic        win_we;
    logic [7:0]  win_addr;
    logic [15:0] win_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            owner      <= 1'b0;
            cpu_gnt    <= 1'b0;
            ext_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ext_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
            owner      <= owner_nxt;
            cpu_gnt    <= launch && !ext_win;
            ext_gnt    <= launch && ext_win;
            ram_en     <= launch;
            ram_we     <= launch && win_we;
            if (launch) begin
                ram_addr  <= win_addr;
                ram_wdata <= win_wdata;
            end
            cpu_rvalid <= rd_done && !owner;
            ext_rvalid <= rd_done && owner;
            if (rd_done && !owner) cpu_rdata <= ram_rdata;
            if (rd_done && owner)  ext_rdata <= ram_rdata;
            busy       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req || ext_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = ram_we ? IDLE : RD_WAIT;
            RD_WAIT: if (wait_cnt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        launch    = (state == IDLE) && (cpu_req || ext_req);
        ext_win   = ext_req && (!cpu_req || (starve_cnt < 4'(EXT_MAX)));
        win_we    = ext_win ? ext_we    : cpu_we;
        win_addr  = ext_win ? ext_addr  : cpu_addr;
        win_wdata = ext_win ? ext_wdata : cpu_wdata;
        rd_done   = (state == RD_WAIT) && (wait_cnt == 2'd0);
        owner_nxt = launch ? ext_win : owner;

        // Only an ext grant over a waiting CPU counts toward starvation.
        starve_nxt = starve_cnt;
        if (launch) starve_nxt = (ext_win && cpu_req) ? starve_cnt + 4'd1 : 4'd0;

        wait_nxt = wait_cnt;
        if (state == ISSUE && !ram_we)
            wait_nxt = 2'(RD_LAT - 1);
        else if (state == RD_WAIT && wait_cnt != 2'd0)
            wait_nxt = wait_cnt - 2'd1;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u_dut (RD_LAT=1) covers arbitration/starvation/throughput,
// u_dut3 (RD_LAT=3) covers reset during a pending read.
module tb_mem_port_arbiter;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // RD_LAT=1 instance signals
    logic        rst, cpu_req, cpu_we, ext_req, ext_we;
    logic [7:0]  cpu_addr, ext_addr, ram_addr;
    logic [15:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, ram_wdata, ram_rdata;
    logic        cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, ram_en, ram_we, busy;

    // RD_LAT=3 instance signals
    logic        b_rst, b_cpu_req, b_cpu_we, b_ext_req, b_ext_we;
    logic [7:0]  b_cpu_addr, b_ext_addr, b_ram_addr;
    logic [15:0] b_cpu_wdata, b_ext_wdata, b_cpu_rdata, b_ext_rdata, b_ram_wdata, b_ram_rdata;
    logic        b_cpu_gnt, b_ext_gnt, b_cpu_rvalid, b_ext_rvalid, b_ram_en, b_ram_we, b_busy;

    mem_port_arbiter #(.RD_LAT(1), .EXT_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.RD_LAT(3), .EXT_MAX(4)) u_dut3 (
        .clk(clk), .rst(b_rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
        .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata),
        .ext_gnt(b_ext_gnt), .ext_rdata(b_ext_rdata), .ext_rvalid(b_ext_rvalid),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM models: latency 1 and 3
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];

    always @(posedge clk) begin
        if (ram_en && ram_we) mem_a[ram_addr] <= ram_wdata;
        pipe_a <= mem_a[ram_addr];
        if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
        pipe_b[0] <= mem_b[b_ram_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign ram_rdata   = pipe_a;
    assign b_ram_rdata = pipe_b[2];

    // Sticky event counters sampled mid-cycle
    int dual_gnt_cnt = 0;
    int we_wo_en_cnt = 0;
    int b_rvalid_cnt = 0;
    always @(negedge clk) begin
        if (cpu_gnt && ext_gnt) dual_gnt_cnt++;
        if (ram_we && !ram_en) we_wo_en_cnt++;
        if (b_cpu_rvalid) b_rvalid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits (bounded) for the next grant on either port of u_dut; 1 = ext.
    task automatic wait_any_gnt(input string tag, output logic is_ext);
        bit ok = 0;
        is_ext = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (cpu_gnt || ext_gnt) begin
                ok = 1;
                is_ext = ext_gnt;
            end
        end
        check({tag, "_timeout"}, 32'(ok), 32'd1);
    endtask

    // Issues one CPU command on u_dut3 and returns at its grant cycle.
    task automatic b_issue(input logic we, input logic [7:0] addr, input logic [15:0] wd);
        bit ok = 0;
        b_cpu_req = 1'b1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wd;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (b_cpu_gnt) ok = 1;
        end
        b_cpu_req = 1'b0;
        check("b_gnt_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic is_ext;
        int   g [4];
        int   p, held_cnt, rv_before;
        logic exp_seq [10];

        rst = 1'b1; b_rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 16'hBEEF;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h40; ext_wdata = 16'h1111;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_ext_req = 1'b0; b_ext_we = 1'b0; b_ext_addr = '0; b_ext_wdata = '0;

        // 1. reset with both requests high
        tick(); tick();
        check("rst_ctrl", {25'd0, cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, ram_en, ram_we, busy}, 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_rdata", {cpu_rdata, ext_rdata}, 32'd0);
        rst = 1'b0; b_rst = 1'b0;
        check("rst_rel_idle", {30'd0, ext_gnt, busy}, 32'd0);
        // 4. simultaneous request: ext first
        tick();
        check("first_gnt", {30'd0, cpu_gnt, ext_gnt}, 32'd1);
        check("first_cmd", {ram_en, ram_we, 6'd0, ram_addr, ram_wdata}, {2'b11, 6'd0, 8'h40, 16'h1111});
        ext_req = 1'b0;
        tick();
        check("idle_between", {29'd0, cpu_gnt, ext_gnt, busy}, 32'd0);
        // 2. CPU write then read back
        tick();
        check("cpu_wr_gnt", {30'd0, cpu_gnt, ext_gnt}, 32'd2);
        check("cpu_wr_cmd", {ram_en, ram_we, 6'd0, ram_addr, ram_wdata}, {2'b11, 6'd0, 8'h12, 16'hBEEF});
        cpu_we = 1'b0; cpu_wdata = 16'h0000;
        tick();
        check("cpu_rd_idle", 32'(cpu_gnt), 32'd0);
        tick();
        check("cpu_rd_gnt", {29'd0, cpu_gnt, ram_en, ram_we}, 32'b110);
        check("cpu_rd_addr", 32'(ram_addr), 32'h12);
        cpu_req = 1'b0;
        tick();
        check("cpu_rd_wait", {30'd0, cpu_rvalid, busy}, 32'b01);
        tick();
        check("cpu_rvalid", {30'd0, cpu_rvalid, ext_rvalid}, 32'b10);
        check("cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        check("ext_rdata_hold", 32'(ext_rdata), 32'h0);

        // 3. starvation bound with both held
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'hC000;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h30; ext_wdata = 16'h3030;
        for (int i = 0; i < 10; i++) exp_seq[i] = (i % 5 != 4);
        for (int i = 0; i < 10; i++) begin
            wait_any_gnt("starve", is_ext);
            check($sformatf("starve_seq%0d", i), 32'(is_ext), 32'(exp_seq[i]));
        end
        cpu_req = 1'b0; ext_req = 1'b0;

        // 6a. held request re-granted once per IDLE
        ext_addr = 8'h50; ext_wdata = 16'h5555; ext_req = 1'b1;
        wait_any_gnt("held", is_ext);
        check("held_owner", 32'(is_ext), 32'd1);
        held_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            held_cnt += int'(ext_gnt);
        end
        ext_req = 1'b0;
        check("held_regrants", 32'(held_cnt), 32'd1);

        // 6b. back-to-back CPU writes 0x00..0x03
        p = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h00; cpu_wdata = 16'hA000;
        for (int k = 0; k < 4; k++) begin
            wait_any_gnt("b2b", is_ext);
            g[k] = cyc;
            cpu_addr = 8'(k + 1); cpu_wdata = 16'hA000 + 16'(k + 1);
        end
        cpu_req = 1'b0;
        check("b2b_first", 32'(g[0] - p), 32'd1);
        check("b2b_span", 32'(g[3] - p), 32'd7);
        tick();
        check("b2b_mem2", 32'(mem_a[2]), 32'hA002);
        check("b2b_mem3", 32'(mem_a[3]), 32'hA003);

        // ext read of 0x12 must leave cpu_rdata alone
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h12;
        wait_any_gnt("ext_rd", is_ext);
        ext_req = 1'b0;
        tick(); tick();
        check("ext_rvalid", {30'd0, cpu_rvalid, ext_rvalid}, 32'b01);
        check("ext_rdata", 32'(ext_rdata), 32'hBEEF);
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'hBEEF);

        // 5. RD_LAT=3: full read, then reset in RD_WAIT
        b_issue(1'b1, 8'h33, 16'h7777);
        tick();
        b_issue(1'b0, 8'h33, 16'h0000);
        tick(); tick(); tick();
        check("b_rd_early", 32'(b_cpu_rvalid), 32'd0);
        tick();
        check("b_rd_rvalid", 32'(b_cpu_rvalid), 32'd1);
        check("b_rd_data", 32'(b_cpu_rdata), 32'h7777);
        b_issue(1'b1, 8'h34, 16'h1234);
        tick();
        b_issue(1'b0, 8'h34, 16'h0000);
        tick();
        check("b_busy_wait", 32'(b_busy), 32'd1);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        rv_before = b_rvalid_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("b_no_rvalid", 32'(b_rvalid_cnt - rv_before), 32'd0);
        check("b_rdata_clr", 32'(b_cpu_rdata), 32'h0);
        check("b_idle", 32'(b_busy), 32'd0);
        b_issue(1'b0, 8'h34, 16'h0000);
        tick(); tick(); tick(); tick();
        check("b_rd2_rvalid", 32'(b_cpu_rvalid), 32'd1);
        check("b_rd2_data", 32'(b_cpu_rdata), 32'h1234);

        check("dual_gnt", 32'(dual_gnt_cnt), 32'd0);
        check("we_without_en", 32'(we_wo_en_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
